// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer.
// Stall bus type, exception codes, vector and FSM encoding.
package pipe_ctrl_pkg;

  localparam int DEF_STALL_W = 10;
  localparam int DEF_CNT_W   = 16;

  localparam logic [31:0] DEF_EXC_VEC = 32'hBFC0_0380;

  typedef logic [DEF_STALL_W-1:0] stall_bus_t;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  localparam logic [31:0] EXC_INT  = 32'h0000_0001;
  localparam logic [31:0] EXC_ADEL = 32'h0000_0004;
  localparam logic [31:0] EXC_ADES = 32'h0000_0005;
  localparam logic [31:0] EXC_SYS  = 32'h0000_0008;
  localparam logic [31:0] EXC_BP   = 32'h0000_0009;
  localparam logic [31:0] EXC_RI   = 32'h0000_000A;
  localparam logic [31:0] EXC_OV   = 32'h0000_000C;
  localparam logic [31:0] EXC_ERET = 32'h0000_000E;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } state_e;

  // ERET returns to EPC; every other code enters the vector.
  function automatic logic [31:0] exc_target(
    input logic [31:0] code,
    input logic [31:0] epc,
    input logic [31:0] vec
  );
    return (code == EXC_ERET) ? epc : vec;
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Sequencer bus: stall requests, exception info, busy in;
// stall bus, flush, redirect PC and stall counter out.
interface pipe_ctrl_if #(
  parameter int STALL_W = 10,
  parameter int CNT_W   = 16
);
  logic [STALL_W-1:0] stallreq_i;
  logic [31:0]        excepttype_i;
  logic [31:0]        cp0_epc_i;
  logic               inst_busy_i;
  logic [STALL_W-1:0] stall_o;
  logic               flush_o;
  logic [31:0]        new_pc_o;
  logic [CNT_W-1:0]   stall_cnt_o;

  modport master (
    output stallreq_i, excepttype_i,
    output cp0_epc_i, inst_busy_i,
    input  stall_o, flush_o,
    input  new_pc_o, stall_cnt_o
  );

  modport slave (
    input  stallreq_i, excepttype_i,
    input  cp0_epc_i, inst_busy_i,
    output stall_o, flush_o,
    output new_pc_o, stall_cnt_o
  );
endinterface

// File: rtl/pipe_ctrl_stall_mask_gen.sv
// Priority thermometer: req_i -> mask_o, every bit at or
// below the highest request set, so that stage freezes.
module pipe_ctrl_stall_mask_gen #(
  parameter int W = 10
) (
  input  logic [W-1:0] req_i,
  output logic [W-1:0] mask_o
);
  logic acc;

  always_comb begin
    acc    = 1'b0;
    mask_o = '0;
    for (int k = W - 1; k >= 0; k--) begin
      acc       = acc | req_i[k];
      mask_o[k] = acc;
    end
  end
endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: stall bus, exception flush/redirect,
// redirect deferral while fetch is busy, stall counter.
module pipe_ctrl #(
  parameter int          STALL_W = pipe_ctrl_pkg::DEF_STALL_W,
  parameter logic [31:0] EXC_VEC = pipe_ctrl_pkg::DEF_EXC_VEC,
  parameter int          CNT_W   = pipe_ctrl_pkg::DEF_CNT_W
) (
  input logic        clk,
  input logic        rst,
  pipe_ctrl_if.slave bus
);
  import pipe_ctrl_pkg::*;

  state_e state_q, state_d;

  logic [31:0]        code_q, code_d;
  logic [31:0]        epc_q, epc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [STALL_W-1:0] mask;
  logic [STALL_W-1:0] stall;
  logic               flush;
  logic [31:0]        new_pc;
  logic               exc_vld;

  pipe_ctrl_stall_mask_gen #(
    .W (STALL_W)
  ) u_mask (
    .req_i  (bus.stallreq_i),
    .mask_o (mask)
  );

  assign exc_vld = |bus.excepttype_i;

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    epc_d   = epc_q;
    stall   = '0;
    flush   = 1'b0;
    new_pc  = '0;
    unique case (state_q)
      RUN: begin
        if (exc_vld && !bus.inst_busy_i) begin
          flush  = 1'b1;
          new_pc = exc_target(bus.excepttype_i,
                              bus.cp0_epc_i, EXC_VEC);
        end else if (exc_vld) begin
          // Fetch in flight: freeze everything and
          // hold the redirect until the bus is idle.
          stall   = '1;
          code_d  = bus.excepttype_i;
          epc_d   = bus.cp0_epc_i;
          state_d = DRAIN;
        end else begin
          stall = mask;
        end
      end
      DRAIN: begin
        if (!bus.inst_busy_i) begin
          flush   = 1'b1;
          new_pc  = exc_target(code_q, epc_q, EXC_VEC);
          state_d = RUN;
        end else begin
          stall = '1;
        end
      end
      default: state_d = RUN;
    endcase
    if (rst) begin
      stall  = '0;
      flush  = 1'b0;
      new_pc = '0;
    end
    if (stall == '0 || flush) begin
      cnt_d = '0;
    end else if (&cnt_q) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      code_q  <= '0;
      epc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      epc_q   <= epc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.stall_o     = stall;
  assign bus.flush_o     = flush;
  assign bus.new_pc_o    = new_pc;
  assign bus.stall_cnt_o = cnt_q;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed cases with
// literal expectations plus random traffic vs a model.
module tb_pipe_ctrl;
  logic clk;
  logic rst;

  pipe_ctrl_if #(.STALL_W(10), .CNT_W(16)) bus ();

  pipe_ctrl #(
    .STALL_W (10),
    .EXC_VEC (32'hBFC0_0380),
    .CNT_W   (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model state: pending redirect and counter value.
  bit          m_pend = 0, n_pend = 0;
  logic [31:0] m_tgt = 0, n_tgt = 0;
  int          m_cnt = 0, n_cnt = 0;
  bit          m_known = 0, n_known = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h @%0t",
               name, act, exp, $time);
    end
  endtask

  task automatic model_check();
    logic [9:0]  e_stall;
    logic        e_flush;
    logic [31:0] e_pc;
    logic [31:0] tgt;
    int          h;
    e_stall = '0;
    e_flush = 1'b0;
    e_pc    = '0;
    n_pend  = m_pend;
    n_tgt   = m_tgt;
    if (rst) begin
      n_pend = 0;
    end else if (m_pend) begin
      if (bus.inst_busy_i) begin
        e_stall = 10'h3FF;
      end else begin
        e_flush = 1'b1;
        e_pc    = m_tgt;
        n_pend  = 0;
      end
    end else if (bus.excepttype_i != 0) begin
      tgt = (bus.excepttype_i == 32'hE) ?
            bus.cp0_epc_i : 32'hBFC0_0380;
      if (bus.inst_busy_i) begin
        e_stall = 10'h3FF;
        n_pend  = 1;
        n_tgt   = tgt;
      end else begin
        e_flush = 1'b1;
        e_pc    = tgt;
      end
    end else begin
      h = -1;
      for (int k = 0; k < 10; k++)
        if (bus.stallreq_i[k]) h = k;
      e_stall = 10'((1 << (h + 1)) - 1);
    end
    if (rst || e_stall == 0 || e_flush) n_cnt = 0;
    else n_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
    n_known = rst ? 1'b1 : m_known;
    chk("stall", 32'(bus.stall_o), 32'(e_stall));
    chk("flush", 32'(bus.flush_o), 32'(e_flush));
    chk("new_pc", bus.new_pc_o, e_pc);
    if (m_known)
      chk("stall_cnt", 32'(bus.stall_cnt_o), 32'(m_cnt));
  endtask

  task automatic cyc(input logic r,
                     input logic [9:0] req,
                     input logic [31:0] exc,
                     input logic [31:0] epc,
                     input logic busy);
    @(posedge clk);
    m_pend  = n_pend;
    m_tgt   = n_tgt;
    m_cnt   = n_cnt;
    m_known = n_known;
    #1;
    rst              = r;
    bus.stallreq_i   = req;
    bus.excepttype_i = exc;
    bus.cp0_epc_i    = epc;
    bus.inst_busy_i  = busy;
    @(negedge clk);
    model_check();
  endtask

  logic [31:0] codes [8];

  initial begin
    codes = '{32'h1, 32'h4, 32'h5, 32'h8,
              32'h9, 32'hA, 32'hC, 32'hE};
    rst              = 1'b1;
    bus.stallreq_i   = '0;
    bus.excepttype_i = '0;
    bus.cp0_epc_i    = '0;
    bus.inst_busy_i  = 1'b0;

    cyc(1, 10'h3FF, 0, 0, 0);
    chk("rst_stall", 32'(bus.stall_o), 0);
    chk("rst_flush", 32'(bus.flush_o), 0);
    cyc(1, 0, 32'hC, 32'h55, 0);
    chk("rst_pc", bus.new_pc_o, 0);
    cyc(0, 0, 0, 0, 0);
    chk("rst_cnt", 32'(bus.stall_cnt_o), 0);

    cyc(0, 10'h010, 0, 0, 0);
    chk("div_mask", 32'(bus.stall_o), 32'h01F);
    chk("div_cnt0", 32'(bus.stall_cnt_o), 0);
    cyc(0, 10'h010, 0, 0, 0);
    chk("div_cnt1", 32'(bus.stall_cnt_o), 1);
    cyc(0, 10'h010, 0, 0, 0);
    chk("div_cnt2", 32'(bus.stall_cnt_o), 2);
    cyc(0, 0, 0, 0, 0);
    chk("div_cnt3", 32'(bus.stall_cnt_o), 3);
    chk("rel_stall", 32'(bus.stall_o), 0);
    cyc(0, 0, 0, 0, 0);
    chk("rel_cnt", 32'(bus.stall_cnt_o), 0);

    cyc(0, 10'h104, 0, 0, 0);
    chk("hi_dom", 32'(bus.stall_o), 32'h1FF);

    cyc(0, 10'h010, 32'hC, 32'h1234, 0);
    chk("ov_flush", 32'(bus.flush_o), 1);
    chk("ov_pc", bus.new_pc_o, 32'hBFC0_0380);
    chk("ov_stall", 32'(bus.stall_o), 0);
    cyc(0, 0, 0, 0, 0);
    chk("ov_once", 32'(bus.flush_o), 0);

    cyc(0, 0, 32'hE, 32'hBFC0_1234, 1);
    chk("eret_d1", 32'(bus.stall_o), 32'h3FF);
    chk("eret_nf", 32'(bus.flush_o), 0);
    cyc(0, 0, 32'hE, 32'h0, 1);
    chk("eret_d2", 32'(bus.stall_o), 32'h3FF);
    cyc(0, 10'h001, 32'h8, 32'h0, 1);
    chk("eret_d3", 32'(bus.stall_o), 32'h3FF);
    cyc(0, 0, 32'hE, 32'h0, 0);
    chk("eret_fl", 32'(bus.flush_o), 1);
    chk("eret_pc", bus.new_pc_o, 32'hBFC0_1234);
    cyc(0, 0, 0, 0, 0);
    chk("eret_1cy", 32'(bus.flush_o), 0);
    chk("eret_pc0", bus.new_pc_o, 0);

    cyc(0, 0, 32'h8, 0, 1);
    chk("dr_stall", 32'(bus.stall_o), 32'h3FF);
    cyc(1, 0, 0, 0, 1);
    chk("dr_rst", 32'(bus.stall_o), 0);
    cyc(0, 0, 0, 0, 1);
    chk("dr_stall2", 32'(bus.stall_o), 0);
    chk("dr_cnt", 32'(bus.stall_cnt_o), 0);
    cyc(0, 0, 0, 0, 0);
    chk("dr_noflush", 32'(bus.flush_o), 0);

    for (int i = 0; i < 3000; i++) begin
      logic        r;
      logic [9:0]  req;
      logic [31:0] exc;
      r   = ($urandom_range(0, 199) == 0);
      req = ($urandom_range(0, 3) == 0) ? 10'h0 :
            10'(($urandom % 1024) >> $urandom_range(0, 9));
      exc = ($urandom_range(0, 4) == 0) ?
            codes[$urandom_range(0, 7)] : 32'h0;
      cyc(r, req, exc, $urandom, 1'($urandom));
    end

    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 65540; i++) cyc(0, 10'h001, 0, 0, 0);
    chk("sat", 32'(bus.stall_cnt_o), 32'hFFFF);
    cyc(0, 10'h001, 0, 0, 0);
    chk("sat_nowrap", 32'(bus.stall_cnt_o), 32'hFFFF);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("sat_clr", 32'(bus.stall_cnt_o), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central pipeline sequencer for the single-issue MIPS core.
- Collects per-stage stall requests and drives the shared stall bus consumed by every pipeline register (PC through WB).
- Turns exceptions and ERET reported from MEM into a flush pulse plus a redirect PC.
- Defers a redirect while an instruction-bus access is still in flight, so the SRAM-like fetch interface is never abandoned mid-transaction.

Parameters:
- STALL_W, 10, width of the stall bus; bit k freezes stage register k; bit 0 is the PC register.
- EXC_VEC, 32'hBFC0_0380, general exception entry address.
- CNT_W, 16, width of the saturating consecutive-stall counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- stallreq_i  in  STALL_W  per-stage stall requests; bit k set = stage k cannot advance
- excepttype_i  in  32  exception code of the instruction in MEM; 0 = none
- cp0_epc_i  in  32  current EPC, used for ERET
- inst_busy_i  in  1  instruction-bus request accepted, data not yet returned
- stall_o  out  STALL_W  stall bus to the pipeline registers
- flush_o  out  1  clears all pipeline registers
- new_pc_o  out  32  redirect target, valid only while flush_o=1
- stall_cnt_o  out  CNT_W  consecutive cycles with any stall_o bit set, saturating

Behaviour:
- Reset and clock: rst is synchronous, active-high; clock is clk.
- Reset values: state=RUN, latched code/EPC=0, stall_cnt_o=0. In the reset cycle the combinational outputs read stall_o=0, flush_o=0, new_pc_o=0.
- Stall mask:
  - h = index of the highest set bit of stallreq_i.
  - stall_o bits 0..h = 1; bits above h = 0. All zero if stallreq_i=0.
  - The mask is combinational, same cycle as the request.
  - Consequence: stage h holds and stage h+1 receives a bubble.
- Exception decode:
  - excepttype_i==32'hE (ERET): target = cp0_epc_i.
  - Any other non-zero code (1 int, 4/5 ADEL/ADES, 8 sys, 9 bp, A ri, C ov): target = EXC_VEC.
- FSM states: RUN, DRAIN.
- RUN:
  - excepttype_i!=0 and inst_busy_i=0: flush_o=1 and new_pc_o=target in the same cycle; stall_o=0 (flush overrides all stall requests); stay RUN.
  - excepttype_i!=0 and inst_busy_i=1: latch the code and target; stall_o=all ones; flush_o=0; go DRAIN.
  - Otherwise: flush_o=0 and stall_o=mask.
- DRAIN:
  - stall_o=all ones, which freezes the excepting instruction in MEM.
  - Inputs excepttype_i and cp0_epc_i are ignored; the latched values are used.
  - When inst_busy_i=0: flush_o=1, new_pc_o=latched target, stall_o=0, go RUN. Flush always lasts exactly 1 cycle.
- new_pc_o when flush_o=0: 0.
- stall_cnt_o:
  - Registered.
  - Next value = 0 if stall_o==0 or flush_o=1; otherwise min(cnt+1, 2^CNT_W-1).
  - The counter updates on the edge after the cycle being counted.
- Boundary cases:
  - Exception together with stall requests: exception wins.
  - inst_busy_i drops in the same cycle the exception arrives: that counts as not busy, so the flush is immediate.
  - rst during DRAIN: go RUN and discard the latched exception; the flush is not issued.
  - A second exception while in DRAIN: ignored, since the MEM stage is frozen.

Decomposition:
- Shared defines header holds:
  - StallBus, Stop/NoStop
  - exception code constants: EXC_INT, EXC_ADEL, EXC_ADES, EXC_SYS, EXC_BP, EXC_RI, EXC_OV, EXC_ERET
  - EXC_VEC
  - the FSM state encoding
- Optional sub-module stall_mask_gen: priority-thermometer encoder, stallreq_i -> stall_o mask.
- Everything else stays inline.

Test Plan:
- stallreq_i=10'b00_0001_0000 (EX div busy), no exception -> stall_o=10'b00_0001_1111, flush_o=0; stall_cnt_o counts 1,2,3 while held, then 0 the cycle after release.
- stallreq_i=10'b01_0000_0100 (MEM wait plus ID load-use) -> stall_o=10'b01_1111_1111, showing the highest request dominates.
- excepttype_i=32'hC, inst_busy_i=0, stallreq_i=10'h010 -> same cycle flush_o=1, new_pc_o=32'hBFC0_0380, stall_o=0; next cycle flush_o=0.
- excepttype_i=32'hE, cp0_epc_i=32'hBFC0_1234, inst_busy_i=1 for 3 cycles:
  - During those 3 cycles: stall_o=10'h3FF, flush_o=0; changing cp0_epc_i to 32'h0 has no effect.
  - Cycle 4: flush_o=1, new_pc_o=32'hBFC0_1234 for exactly 1 cycle.
- rst asserted in DRAIN -> next cycle stall_o=0, flush_o=0, stall_cnt_o=0; no later flush once inst_busy_i drops.
- Hold stallreq_i=10'h001 for 70000 cycles with CNT_W=16 -> stall_cnt_o saturates at 16'hFFFF and does not wrap.
